// File: rtl/spi_word_streamer_if.sv
// Handshake bundle between the SPI word collector, the streamer and the
// downstream serial consumer.
interface spi_word_streamer_if #(
  parameter int WORD_WIDTH = 96,
  parameter int DEPTH      = 2
);
  logic                       word_valid;
  logic [WORD_WIDTH-1:0]      word_in;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_data;
  logic                       out_first;
  logic                       out_last;
  logic                       overflow;
  logic [$clog2(DEPTH+1)-1:0] level;

  modport master (
    output word_valid, word_in, out_ready,
    input  out_valid, out_data, out_first, out_last, overflow, level
  );

  modport slave (
    input  word_valid, word_in, out_ready,
    output out_valid, out_data, out_first, out_last, overflow, level
  );
endinterface

// File: rtl/spi_word_streamer.sv
// Ping-pong word buffer that re-serialises captured SPI words bit 0 first
// onto a valid/ready bit stream, flagging words dropped on overflow.
//
// state  | meaning
// IDLE   | buffer empty, out_valid low
// STREAM | presenting bit bit_idx of slot rd_ptr
module spi_word_streamer #(
  parameter int WORD_WIDTH = 96,
  parameter int DEPTH      = 2
) (
  input logic clk,
  input logic resetN,
  spi_word_streamer_if.slave bus
);
  localparam int BW = $clog2(WORD_WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic                  overflow_q, overflow_d;

  logic streaming, last_bit, xfer, pop, wr_acc;

  always_comb begin
    streaming  = (state_q == STREAM);
    last_bit   = (bit_idx_q == BW'(WORD_WIDTH-1));
    xfer       = streaming && bus.out_ready;
    pop        = xfer && last_bit;
    // A full buffer can still take a word if the head slot frees this cycle.
    wr_acc     = bus.word_valid && ((count_q != CW'(DEPTH)) || pop);
    count_d    = count_q + CW'(wr_acc) - CW'(pop);
    wr_ptr_d   = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    overflow_d = overflow_q || (bus.word_valid && !wr_acc);

    bit_idx_d = bit_idx_q;
    if (pop)
      bit_idx_d = '0;
    else if (xfer)
      bit_idx_d = bit_idx_q + BW'(1);

    state_d = state_q;
    case (state_q)
      IDLE:    if (count_d != '0) state_d = STREAM;
      STREAM:  if (pop && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      bit_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      bit_idx_q  <= bit_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Slot storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (resetN && wr_acc)
      mem_q[wr_ptr_q] <= bus.word_in;
  end

  assign bus.out_valid = streaming;
  assign bus.out_data  = streaming && mem_q[rd_ptr_q][bit_idx_q];
  assign bus.out_first = streaming && (bit_idx_q == '0);
  assign bus.out_last  = streaming && last_bit;
  assign bus.overflow  = overflow_q;
  assign bus.level     = count_q;
endmodule

// File: doc/spi_word_streamer.md
Name: spi_word_streamer

Overview:
- Downstream consumer of the SPI serial-to-parallel collector.
- Captures each completed parallel word into a small ping-pong buffer.
- Re-serialises each word bit-by-bit, first-received bit first, over a valid/ready stream toward the WiMAX PHY chain (randomizer input).
- Decouples SPI arrival timing from downstream backpressure, and flags any words lost to overflow.

Parameters:
WORD_WIDTH, 96, bits per captured word (must match the collector's parallel width)
DEPTH, 2, number of word slots in the buffer (power of two, >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
resetN  input  1  synchronous active-low reset
word_valid  input  1  capture strobe, driven by collector parallel_ready
word_in  input  WORD_WIDTH  collected word; bit 0 = first serial bit received
out_valid  output  1  out_data holds a valid bit
out_ready  input  1  downstream accepts the bit this cycle
out_data  output  1  current serial bit
out_first  output  1  out_data is bit 0 of a word
out_last  output  1  out_data is bit WORD_WIDTH-1 of a word
overflow  output  1  sticky: at least one word was dropped
level  output  $clog2(DEPTH+1)  number of occupied slots

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: resetN low at a rising edge of clk clears all state.
  - Cleared state: wr_ptr, rd_ptr, count, bit_idx, overflow and FSM (to IDLE).
  - Buffer contents are not cleared.
  - Outputs after reset: out_valid=0, out_data=0, out_first=0, out_last=0, overflow=0, level=0.
  - Reset mid-stream aborts the current word with no partial output afterwards.
- Transfer and pop:
  - A transfer occurs on a cycle with out_valid && out_ready.
  - A pop occurs on a transfer with out_last=1. It frees slot rd_ptr, rd_ptr wraps modulo DEPTH, and bit_idx returns to 0.
- Write side:
  - word_valid=1 with count<DEPTH: word_in is written to slot wr_ptr, wr_ptr wraps modulo DEPTH, count increments.
  - word_valid=1 with count==DEPTH and a pop in the same cycle: the write is accepted and count is unchanged.
  - word_valid=1 with count==DEPTH and no pop: the word is dropped, overflow is set and stays set until reset, and buffer/pointers are unchanged.
  - Each cycle word_valid is high is a separate capture request. The collector pulses it for one cycle per word.
- count update:
  - next count = count + accepted_write - pop.
  - level = count.
- Read FSM, two states, registered:
  - IDLE: out_valid=0. Go to STREAM when next count != 0.
  - STREAM: out_valid=1, out_data = slot[rd_ptr][bit_idx].
    - Transfer with out_last=0: bit_idx increments.
    - Pop with next count != 0: stay in STREAM. The next word starts the following cycle with bit_idx=0 and no bubble.
    - Pop with next count == 0: go to IDLE.
    - out_ready=0: hold bit_idx and out_data stable. out_valid does not drop once asserted until the word completes.
- Latency: word_valid at cycle t into an empty buffer gives out_valid=1 with out_first=1 at cycle t+1.
- Markers:
  - out_first = STREAM && bit_idx==0.
  - out_last = STREAM && bit_idx==WORD_WIDTH-1.
  - out_data, out_first and out_last are 0 in IDLE.
- Widths and wrap:
  - bit_idx is $clog2(WORD_WIDTH) bits and wraps explicitly at WORD_WIDTH-1 (96 is not a power of two).
  - Pointers are $clog2(DEPTH) bits with natural wrap.
- Order: bits leave in the same order they arrived on the SPI line, bit 0 first.

Test Plan:
- Single word: reset, word_in=96'h0123_4567_89AB_CDEF_0011_2233, 1-cycle word_valid, out_ready=1.
  - Required: out_valid high 96 consecutive cycles starting the next cycle.
  - Required: bits equal word_in[0..95] in order, out_first on cycle 1, out_last on cycle 96, then out_valid=0 and level=0.
- Back-to-back: two words A and B, 5 cycles apart, out_ready=1.
  - Required: 192 contiguous valid bits, A then B, out_first asserted exactly at bits 0 and 96.
  - Required: level peaks at 2, overflow=0.
- Backpressure: out_ready toggling 1010…, plus out_ready held low 20 cycles at bit 40.
  - Required: out_data/out_first/out_last stable while stalled, no bits lost or duplicated, exact order preserved.
- Overflow: out_ready=0, three word_valid pulses (W0, W1, W2).
  - Required: level=2 and overflow=1 after W2.
  - Then out_ready=1 → required: W0 then W1 streamed, W2 never appears.
- Full with simultaneous pop: buffer full, word_valid coinciding with the out_last transfer of the current word.
  - Required: word accepted, level stays 2, overflow stays 0, and the new word streams after the remaining queued word.
- Reset mid-stream: resetN low one cycle at bit 50 of a word with another queued.
  - Required: next cycle out_valid=0, level=0, overflow=0.
  - Then a fresh word streams correctly from bit 0.
